// File: rtl/hex_segment_driver.sv
// Four-digit active-low seven-segment driver with frame-synchronous shadow load,
// frame PWM dimming and optional per-digit blink (HEX_SEGMENT_DRIVER_BLINK_EN).
module hex_segment_driver #(
  parameter int PWM_BITS  = 4,
  parameter int PRESCALE  = 64,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         seg_word,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [3:0]          blink_mask,
  input  logic                enable,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3,
  output logic                frame_start
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PRESC_MAX = PSW'(PRESCALE - 1);
  localparam logic [31:0] SHADOW_RST = 32'h40404040;

  logic [PSW-1:0]      presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0]         shadow_q, shadow_d;
  logic                frame_start_q, frame_start_d;
  logic [6:0]          hex_q [4];
  logic [6:0]          hex_d [4];
  logic                step;
  logic                frame;
  logic                lit;
  logic [3:0]          blank;

`ifdef HEX_SEGMENT_DRIVER_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    bcnt_d        = (bcnt_q == BCNT_MAX) ? '0 : bcnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ (bcnt_q == BCNT_MAX);
    blank         = blink_mask & {4{blink_phase_q}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q        <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      bcnt_q        <= bcnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blank = 4'b0000;
`endif

  always_comb begin
    step          = (presc_q == PRESC_MAX);
    presc_d       = step ? '0 : presc_q + 1'b1;
    pwm_cnt_d     = step ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    frame         = step && (&pwm_cnt_q);
    // The decimal-point bit of each byte is never driven to the pins.
    shadow_d      = frame ? (seg_word & 32'h7F7F7F7F) : shadow_q;
    frame_start_d = frame;
    lit           = enable && (pwm_cnt_q <= brightness);
    // Output stage reads the next shadow so a new frame shows with frame_start.
    for (int i = 0; i < 4; i++) begin
      hex_d[i] = (lit && !blank[i]) ? shadow_d[8*i +: 7] : 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      shadow_q      <= SHADOW_RST;
      frame_start_q <= 1'b0;
      for (int i = 0; i < 4; i++) hex_q[i] <= 7'h7F;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_q      <= shadow_d;
      frame_start_q <= frame_start_d;
      for (int i = 0; i < 4; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign hex0        = hex_q[0];
  assign hex1        = hex_q[1];
  assign hex2        = hex_q[2];
  assign hex3        = hex_q[3];
  assign frame_start = frame_start_q;

endmodule

// File: doc/hex_segment_driver.md
# hex_segment_driver

Drives four active-low seven-segment digits from the 32-bit segment word produced by the upstream Avalon hex-display PIO. It loads that word into a shadow register only at frame boundaries, so the displays never tear. It dims the digits with a frame-based PWM and can blink selected digits. The block sits between the PIO's `out_port` and the board's HEX pins.

## Interface
Parameters:
- `PWM_BITS`, 4: width of the PWM counter and of `brightness`. Frame = 2^PWM_BITS PWM steps.
- `PRESCALE`, 64: clocks per PWM step, ≥1.
- `BLINK_DIV`, 25000000: clocks per blink half-period, ≥2.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `seg_word`, in, 32: digit i pattern = `seg_word[8i+6:8i]`, active-low; bit 8i+7 ignored.
- `brightness`, in, PWM_BITS: PWM duty level.
- `blink_mask`, in, 4: bit i set → digit i blinks.
- `enable`, in, 1: 0 blanks all digits.
- `hex0`..`hex3`, out, 7 each: registered segment outputs, active-low. Reset value 7'h7F.
- `frame_start`, out, 1: one-cycle pulse when the shadow register loads. Reset value 0.

## Operation
- Prescaler `presc` counts 0..PRESCALE-1 and wraps; `step` is asserted when `presc` == PRESCALE-1.
- PWM counter `pwm_cnt` (PWM_BITS wide) increments on `step` and wraps from all-ones to 0.
- Frame boundary is the edge where `step` is asserted and `pwm_cnt` is all-ones. At that edge:
  - shadow ← `seg_word` with bit 7 of each byte cleared;
  - `frame_start` is high on the following cycle.
- Shadow reset value: 32'h40404040, so each digit shows '0'.
- `seg_word` changes between frame boundaries have no effect on the outputs.
- `lit` = `enable` && (`pwm_cnt` <= `brightness`). Duty = (brightness+1)/2^PWM_BITS, so all-ones means fully on.
- Blink: counter `bcnt` counts 0..BLINK_DIV-1. `blink_phase` toggles at the terminal count. Both reset to 0 (phase 0 = visible).
- Per digit i, `hex_i` is registered as:
  - the shadow byte i [6:0] if `lit` && !(`blink_mask[i]` && `blink_phase`);
  - 7'h7F otherwise.
- Prescaler, PWM and blink counters run regardless of `enable`. The shadow also keeps loading while `enable` is 0.

## Timing
- Outputs are registered: one clock from the counter/shadow state to the `hex_i` pins.
- The first visible frame after reset uses the shadow reset value. The `seg_word` present at the first boundary (PRESCALE·2^PWM_BITS clocks after reset release) appears on the `hex_i` outputs on the cycle `frame_start` is high.
- `brightness`, `enable` and `blink_mask` are not frame-synchronised; a change shows on the outputs one clock later.
- Reset assertion mid-frame clears immediately:
  - presc, pwm_cnt, bcnt, blink_phase → 0;
  - shadow → 32'h40404040;
  - outputs → 7'h7F; `frame_start` → 0.
- First clock edge after reset release: `hex_i` shows 0x40 if `enable` is 1 and brightness ≥ 0, since `pwm_cnt` = 0 always satisfies the duty condition.

## Configuration
- `HEX_SEGMENT_DRIVER_BLINK_EN` defined: the blink counter, `blink_phase` and the `blink_mask` gating are compiled in as described.
- Not defined: no blink logic is built, `blink_mask` is ignored, and digits are gated by `lit` only.

## Test plan
- Reset/first frame: PRESCALE=1, PWM_BITS=4, brightness=15, enable=1, seg_word=0x19302479 → hex0..3=0x40 from the first clock after reset release until the cycle `frame_start` is high (16 clocks after release), then hex0=0x79, hex1=0x24, hex2=0x30, hex3=0x19.
- Tearing guard: change seg_word to 0xC0C0C0C0 at pwm_cnt=5 → outputs unchanged until the next `frame_start`, then all digits 0x40 (bit 7 stripped).
- PWM duty: PRESCALE=1, brightness=3 → each digit shows its pattern for exactly 4 of every 16 clocks and 7'h7F for the other 12; brightness=0 → 1 of 16.
- Blink (macro defined): BLINK_DIV=8, blink_mask=4'b0010, brightness=15 → hex1 alternates 8 clocks of pattern and 8 clocks of 7'h7F; hex0, hex2 and hex3 stay steady. With the macro undefined, hex1 stays steady.
- Enable and reset mid-operation: drop enable → all 7'h7F next clock while `frame_start` pulses continue every 16 clocks. Assert reset_n=0 mid-frame → outputs 7'h7F immediately; after release, digits show 0x40.
